// File: rtl/red_seq_pkg.sv
// Shared constants and types for the red_seq byte-reduction sequencer.
package red_seq_pkg;

    // Controller states; encodings are fixed so external checkers can decode them.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ACC  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // Four bytes per request, so a 2-bit step count covers steps 0..3.
    localparam int unsigned STEP_W   = 2;
    localparam logic [STEP_W-1:0] LAST_STEP = 2'd3;

    // Accumulator wide enough for four worst-case signed bytes (-512..508).
    localparam int unsigned ACC_W    = 10;
    localparam int unsigned RESULT_W = 16;

    // Saturating-mode clamp limits, as signed bytes.
    localparam logic [7:0] SAT_MAX = 8'h7F;
    localparam logic [7:0] SAT_MIN = 8'h80;

    // Sign-extend the accumulator onto the result bus.
    function automatic logic [RESULT_W-1:0] sext_result(input logic [ACC_W-1:0] acc);
        return {{(RESULT_W-ACC_W){acc[ACC_W-1]}}, acc};
    endfunction

endpackage

// File: rtl/red_seq_if.sv
// Request/response bundle for red_seq.
// Handshake: start is a one-cycle request sampled only when the block is idle
// or finishing (IDLE/DONE); operands and sat are captured on that same edge.
// busy is high while accumulating, done pulses for one cycle when result is
// valid; result then holds until the next completion.
interface red_seq_if;
    import red_seq_pkg::*;

    logic                start;
    logic                sat;
    logic [15:0]         a;
    logic [15:0]         b;
    logic                busy;
    logic                done;
    logic [RESULT_W-1:0] result;

    // Requester side (testbench or upstream logic).
    modport master (
        output start, sat, a, b,
        input  busy, done, result
    );

    // Sequencer side.
    modport slave (
        input  start, sat, a, b,
        output busy, done, result
    );
endinterface

// File: rtl/red_seq_sat_step.sv
// One reduction step: accumulator plus a sign-extended byte, optionally
// clamped to the signed-byte range.
module sat_step
    import red_seq_pkg::*;
(
    input  logic [ACC_W-1:0] acc_i,
    input  logic [7:0]       byte_i,
    input  logic             sat_i,
    output logic [ACC_W-1:0] sum_o
);

    logic signed [ACC_W:0] wide;
    logic signed [ACC_W:0] hi_lim;
    logic signed [ACC_W:0] lo_lim;

    // Add one guard bit wider than the accumulator so the clamp compare never wraps.
    always_comb begin
        hi_lim = $signed({{(ACC_W+1-8){SAT_MAX[7]}}, SAT_MAX});
        lo_lim = $signed({{(ACC_W+1-8){SAT_MIN[7]}}, SAT_MIN});
        wide   = $signed({acc_i[ACC_W-1], acc_i}) +
                 $signed({{(ACC_W+1-8){byte_i[7]}}, byte_i});
        sum_o  = wide[ACC_W-1:0];
        if (sat_i) begin
            if (wide > hi_lim) begin
                sum_o = hi_lim[ACC_W-1:0];
            end else if (wide < lo_lim) begin
                sum_o = lo_lim[ACC_W-1:0];
            end
        end
    end

endmodule

// File: rtl/red_seq.sv
// Byte-reduction sequencer: sums the four signed bytes of {b, a} over four
// cycles with a single shared adder, optionally saturating after every step.
module red_seq
    import red_seq_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    red_seq_if.slave     bus,
    output state_e       state_o
);

    state_e              state_q, state_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [31:0]         ops_q, ops_d;
    logic                sat_q, sat_d;
    logic [RESULT_W-1:0] result_q, result_d;

    logic [7:0]          cur_byte;
    logic [ACC_W-1:0]    step_sum;

    // Step k consumes byte k of {b, a}: a[7:0], a[15:8], b[7:0], b[15:8].
    always_comb begin
        cur_byte = ops_q[{step_q, 3'b000} +: 8];
    end

    sat_step u_sat_step (
        .acc_i  (acc_q),
        .byte_i (cur_byte),
        .sat_i  (sat_q),
        .sum_o  (step_sum)
    );

    // Next-state and datapath updates; start is honoured only in IDLE or DONE.
    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        acc_d    = acc_q;
        ops_d    = ops_q;
        sat_d    = sat_q;
        result_d = result_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    ops_d   = {bus.b, bus.a};
                    sat_d   = bus.sat;
                    acc_d   = '0;
                    step_d  = '0;
                    state_d = ST_ACC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACC: begin
                acc_d  = step_sum;
                step_d = step_q + 1'b1;
                if (step_q == LAST_STEP) begin
                    result_d = sext_result(step_sum);
                    state_d  = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears everything asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            step_q   <= '0;
            acc_q    <= '0;
            ops_q    <= '0;
            sat_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            acc_q    <= acc_d;
            ops_q    <= ops_d;
            sat_q    <= sat_d;
            result_q <= result_d;
        end
    end

    // Status outputs are pure state decodes, so reset takes effect at once.
    always_comb begin
        bus.busy   = (state_q == ST_ACC);
        bus.done   = (state_q == ST_DONE);
        bus.result = result_q;
        state_o    = state_q;
    end

endmodule

// File: tb/tb_red_seq.sv
// Directed bench for red_seq: a vector table of reductions plus hand-written
// sequences for start-during-ACC, mid-ACC reset and back-to-back starts.
module tb_red_seq;
    import red_seq_pkg::*;

    logic   clk;
    logic   rst;
    state_e state;

    red_seq_if bus ();

    red_seq dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .state_o (state)
    );

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sat;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[7];

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one cycle; inputs are driven and outputs sampled at negedge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Issue a request and check busy for four cycles then the done cycle.
    // Operands are scrambled after capture to prove they are not re-sampled.
    // Returns at the negedge of the DONE cycle with start low.
    task automatic run_op(input string name, input logic [15:0] a, input logic [15:0] b,
                          input logic sat, input logic [15:0] exp);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        bus.sat   = sat;
        step();
        bus.start = 1'b0;
        bus.a     = 16'($urandom);
        bus.b     = 16'($urandom);
        bus.sat   = 1'($urandom_range(0, 1));
        for (int i = 0; i < 4; i++) begin
            check({name, " busy"}, {15'd0, bus.busy}, 16'd1);
            check({name, " done_low"}, {15'd0, bus.done}, 16'd0);
            if (i < 3) step();
        end
        step();
        check({name, " done"}, {15'd0, bus.done}, 16'd1);
        check({name, " busy_low"}, {15'd0, bus.busy}, 16'd0);
        check({name, " result"}, bus.result, exp);
    endtask

    initial begin
        vecs[0] = '{a: 16'h0102, b: 16'h0304, sat: 1'b0, exp: 16'h000A};
        vecs[1] = '{a: 16'h7F7F, b: 16'h7F7F, sat: 1'b0, exp: 16'h01FC};
        vecs[2] = '{a: 16'h7F7F, b: 16'h7F7F, sat: 1'b1, exp: 16'h007F};
        vecs[3] = '{a: 16'h8080, b: 16'h8080, sat: 1'b0, exp: 16'hFE00};
        vecs[4] = '{a: 16'h8080, b: 16'h8080, sat: 1'b1, exp: 16'hFF80};
        vecs[5] = '{a: 16'h7F7F, b: 16'h0180, sat: 1'b1, exp: 16'h0000};
        vecs[6] = '{a: 16'h7F7F, b: 16'h0180, sat: 1'b0, exp: 16'h007F};

        // Reset
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.sat   = 1'b0;
        repeat (2) @(negedge clk);
        check("reset busy", {15'd0, bus.busy}, 16'd0);
        check("reset done", {15'd0, bus.done}, 16'd0);
        check("reset result", bus.result, 16'h0000);
        check("reset state", {14'd0, state}, {14'd0, ST_IDLE});
        rst = 1'b0;
        @(negedge clk);

        // Vector table
        for (int v = 0; v < 7; v++) begin
            run_op($sformatf("vec%0d", v), vecs[v].a, vecs[v].b, vecs[v].sat, vecs[v].exp);
            step();
            check($sformatf("vec%0d idle", v), {14'd0, state}, {14'd0, ST_IDLE});
            check($sformatf("vec%0d done_once", v), {15'd0, bus.done}, 16'd0);
            check($sformatf("vec%0d hold", v), bus.result, vecs[v].exp);
        end

        // Start pulsed during ACC is ignored
        bus.start = 1'b1;
        bus.a     = 16'h0102;
        bus.b     = 16'h0304;
        bus.sat   = 1'b0;
        step();
        step();
        bus.start = 1'b1;
        bus.a     = 16'h7F7F;
        bus.b     = 16'h7F7F;
        bus.sat   = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        step();
        check("acc_start done", {15'd0, bus.done}, 16'd1);
        check("acc_start result", bus.result, 16'h000A);
        step();
        check("acc_start idle", {14'd0, state}, {14'd0, ST_IDLE});

        // Reset asserted at step 2 clears outputs immediately
        bus.start = 1'b1;
        bus.a     = 16'h7F7F;
        bus.b     = 16'h7F7F;
        bus.sat   = 1'b0;
        step();
        bus.start = 1'b0;
        step();
        step();
        check("rst_mid busy_before", {15'd0, bus.busy}, 16'd1);
        rst = 1'b1;
        #1;
        check("rst_mid busy", {15'd0, bus.busy}, 16'd0);
        check("rst_mid done", {15'd0, bus.done}, 16'd0);
        check("rst_mid result", bus.result, 16'h0000);
        check("rst_mid state", {14'd0, state}, {14'd0, ST_IDLE});
        @(negedge clk);
        rst = 1'b0;

        // First edge after reset release accepts start
        run_op("post_rst", 16'h0102, 16'h0304, 1'b0, 16'h000A);

        // Back-to-back: start held in the DONE cycle
        step();
        run_op("b2b_first", 16'h0001, 16'h0000, 1'b0, 16'h0001);
        bus.start = 1'b1;
        bus.a     = 16'h0001;
        bus.b     = 16'h0000;
        bus.sat   = 1'b0;
        step();
        bus.start = 1'b0;
        check("b2b busy_next", {15'd0, bus.busy}, 16'd1);
        check("b2b done_low", {15'd0, bus.done}, 16'd0);
        step();
        step();
        step();
        check("b2b busy_last", {15'd0, bus.busy}, 16'd1);
        step();
        check("b2b done", {15'd0, bus.done}, 16'd1);
        check("b2b result", bus.result, 16'h0001);
        step();
        check("b2b idle", {14'd0, state}, {14'd0, ST_IDLE});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
